// File: rtl/nco_sweep_pkg.sv
// Shared definitions for the NCO frequency-sweep controller.
// Optional feature macro used by this codebase slice: NCO_SWEEP_TRIANGLE_EN.
package nco_sweep_pkg;

  localparam int unsigned PHASE_ACC_BITS_DEF = 24;
  localparam int unsigned DWELL_BITS_DEF     = 16;

  // Fixed encodings kept so older netlists and probes still decode the state.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DWELL = 2'd1;
  localparam logic [1:0] ST_STEP  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_DWELL = ST_DWELL,
    S_STEP  = ST_STEP,
    S_DONE  = ST_DONE
  } sweep_state_t;

endpackage

// File: rtl/nco_dwell_timer.sv
// Dwell countdown: loads a hold count, decrements to zero, flags zero.
// Optional feature macro of this slice (unused here): NCO_SWEEP_TRIANGLE_EN.
module nco_dwell_timer
  import nco_sweep_pkg::*;
#(
  parameter int unsigned DWELL_BITS = DWELL_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  dec,
  input  logic [DWELL_BITS-1:0] load_val,
  output logic                  zero
);

  logic [DWELL_BITS-1:0] count;

  // Load has priority; the count saturates at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - DWELL_BITS'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// NCO frequency-sweep controller: steps phase_inc from f_start towards f_stop
// in f_step increments, holding each value dwell+1 cycles, with clamping at
// f_stop, optional looping, abort and a done pulse.
// Macro NCO_SWEEP_TRIANGLE_EN: loop mode sweeps back and forth instead of
// reloading f_start (sawtooth) at the end of each pass.
module nco_sweep_ctrl
  import nco_sweep_pkg::*;
#(
  parameter int unsigned PHASE_ACC_BITS = PHASE_ACC_BITS_DEF,
  parameter int unsigned DWELL_BITS     = DWELL_BITS_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      loop_en,
  input  logic [PHASE_ACC_BITS-2:0] f_start,
  input  logic [PHASE_ACC_BITS-2:0] f_stop,
  input  logic [PHASE_ACC_BITS-2:0] f_step,
  input  logic [DWELL_BITS-1:0]     dwell,
  output logic [PHASE_ACC_BITS-2:0] phase_inc,
  output logic                      inc_upd,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned W = PHASE_ACC_BITS - 1;

  sweep_state_t state, state_n;

  // Configuration captured when a start is accepted.
  logic [W-1:0]          f_start_q, f_stop_q, f_step_q;
  logic [DWELL_BITS-1:0] dwell_q;
  logic                  loop_q;
  logic                  dir_up_q;

  // Endpoint the current pass is heading to.
  logic [W-1:0] target;

  logic [W-1:0]          phase_n;
  logic                  upd_n;
  logic                  latch_en;
  logic                  tmr_load, tmr_dec, tmr_zero;
  logic [DWELL_BITS-1:0] tmr_val;

  logic [PHASE_ACC_BITS-1:0] cur_ext, stp_ext, tgt_ext, sum, diff;
  logic [W-1:0]              step_val;

`ifdef NCO_SWEEP_TRIANGLE_EN
  logic         flip;
  logic [W-1:0] target_q;

  assign target = target_q;
`else
  assign target = f_stop_q;
`endif

  nco_dwell_timer #(
    .DWELL_BITS(DWELL_BITS)
  ) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Next step value, one bit wider than phase_inc so overshoot and
  // underflow are both visible before clamping to the target.
  always_comb begin
    cur_ext = {1'b0, phase_inc};
    stp_ext = {1'b0, f_step_q};
    tgt_ext = {1'b0, target};
    sum     = cur_ext + stp_ext;
    diff    = cur_ext - stp_ext;
    if (dir_up_q) begin
      step_val = (sum > tgt_ext) ? target : sum[W-1:0];
    end else begin
      step_val = (diff[PHASE_ACC_BITS-1] || (diff < tgt_ext)) ? target : diff[W-1:0];
    end
  end

  // Sweep sequencing: next state, next phase_inc and timer control.
  always_comb begin
    state_n  = state;
    phase_n  = phase_inc;
    upd_n    = 1'b0;
    latch_en = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = dwell_q;
`ifdef NCO_SWEEP_TRIANGLE_EN
    flip     = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          latch_en = 1'b1;
          phase_n  = f_start;
          upd_n    = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = dwell;
          state_n  = S_DWELL;
        end
      end
      S_DWELL: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else if ((phase_inc != target) && (f_step_q != '0)) begin
          state_n = S_STEP;
        end else if (!loop_q) begin
          state_n = S_DONE;
        end else begin
`ifdef NCO_SWEEP_TRIANGLE_EN
          // Reverse through a normal STEP cycle; a degenerate sweep
          // (single frequency) simply reloads its one value.
          if ((f_step_q != '0) && (f_start_q != f_stop_q)) begin
            flip    = 1'b1;
            state_n = S_STEP;
          end else begin
            phase_n  = f_start_q;
            upd_n    = 1'b1;
            tmr_load = 1'b1;
            state_n  = S_DWELL;
          end
`else
          phase_n  = f_start_q;
          upd_n    = 1'b1;
          tmr_load = 1'b1;
          state_n  = S_DWELL;
`endif
        end
      end
      S_STEP: begin
        if (abort) begin
          state_n = S_IDLE;
        end else begin
          phase_n  = step_val;
          upd_n    = 1'b1;
          tmr_load = 1'b1;
          state_n  = S_DWELL;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Registered state and outputs; busy/done are derived from the next state
  // so that they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      phase_inc <= '0;
      inc_upd   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      phase_inc <= phase_n;
      inc_upd   <= upd_n;
      busy      <= (state_n != S_IDLE);
      done      <= (state_n == S_DONE);
    end
  end

  // Configuration latch, written only on an accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_start_q <= '0;
      f_stop_q  <= '0;
      f_step_q  <= '0;
      dwell_q   <= '0;
      loop_q    <= 1'b0;
      dir_up_q  <= 1'b0;
    end else if (latch_en) begin
      f_start_q <= f_start;
      f_stop_q  <= f_stop;
      f_step_q  <= f_step;
      dwell_q   <= dwell;
      loop_q    <= loop_en;
      dir_up_q  <= (f_stop >= f_start);
    end
`ifdef NCO_SWEEP_TRIANGLE_EN
    else if (flip) begin
      dir_up_q <= ~dir_up_q;
    end
`endif
  end

`ifdef NCO_SWEEP_TRIANGLE_EN
  // Pass endpoint: f_stop on accept, then alternates between the two ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      target_q <= '0;
    end else if (latch_en) begin
      target_q <= f_stop;
    end else if (flip) begin
      target_q <= (target_q == f_stop_q) ? f_start_q : f_stop_q;
    end
  end
`endif

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: directed table, loop/abort/reset
// sequences and randomized sweeps against a value-list reference model.
module tb_nco_sweep_ctrl;

  localparam int unsigned PA = 24;
  localparam int unsigned DB = 16;
  localparam int unsigned W  = PA - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort, loop_en;
  logic [W-1:0]  f_start, f_stop, f_step;
  logic [DB-1:0] dwell;
  logic [W-1:0]  phase_inc;
  logic          inc_upd, busy, done;

  int unsigned nvec = 0;
  int unsigned nmis = 0;

  nco_sweep_ctrl #(
    .PHASE_ACC_BITS(PA),
    .DWELL_BITS    (DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .loop_en   (loop_en),
    .f_start   (f_start),
    .f_stop    (f_stop),
    .f_step    (f_step),
    .dwell     (dwell),
    .phase_inc (phase_inc),
    .inc_upd   (inc_upd),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]      fs;
    logic [W-1:0]      fe;
    logic [W-1:0]      st;
    logic [DB-1:0]     dw;
    logic [3:0]        n;
    logic [4:0][W-1:0] vals;
    logic [15:0]       busy_cyc;
  } vec_t;

  vec_t tbl [8];

  function automatic vec_t mk(input int unsigned fs, fe, st, dw, n, bc,
                              input int unsigned v0, v1, v2, v3, v4);
    vec_t r;
    r.fs = W'(fs); r.fe = W'(fe); r.st = W'(st); r.dw = DB'(dw);
    r.n = 4'(n); r.busy_cyc = 16'(bc);
    r.vals[0] = W'(v0); r.vals[1] = W'(v1); r.vals[2] = W'(v2);
    r.vals[3] = W'(v3); r.vals[4] = W'(v4);
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [25:0] outs();
    return {busy, done, inc_upd, phase_inc};
  endfunction

  // Accept a sweep, then scramble the inputs: latched values must govern.
  task automatic start_sweep(input logic [W-1:0] fs, fe, st, input logic [DB-1:0] dw,
                             input logic lp);
    @(negedge clk);
    f_start = fs; f_stop = fe; f_step = st; dwell = dw; loop_en = lp; start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    f_start = W'($urandom);
    f_stop  = W'($urandom);
    f_step  = W'($urandom);
    dwell   = DB'($urandom);
    loop_en = 1'($urandom);
  endtask

  // Reference: list of frequencies visited, from the sweep rules alone.
  logic [25:0] exp_q[$];

  task automatic build_trace(input longint fs, fe, st, dw);
    longint vals[$];
    longint v;
    vals.delete();
    exp_q.delete();
    v = fs;
    vals.push_back(v);
    while (v != fe && st != 0) begin
      if (fe >= fs) v = (v + st > fe) ? fe : v + st;
      else          v = (v < fe + st) ? fe : v - st;
      vals.push_back(v);
    end
    foreach (vals[i]) begin
      for (longint c = 0; c <= dw; c++)
        exp_q.push_back({1'b1, 1'b0, (c == 0), W'(vals[i])});
      if (i != vals.size() - 1)
        exp_q.push_back({1'b1, 1'b0, 1'b0, W'(vals[i])});
    end
    exp_q.push_back({1'b1, 1'b1, 1'b0, W'(vals[vals.size()-1])});
    exp_q.push_back({1'b0, 1'b0, 1'b0, W'(vals[vals.size()-1])});
  endtask

  initial begin
    int unsigned loop_exp [7];
    logic [W-1:0] got [$];
    int unsigned bcnt, dcnt, kpulse;
    bit found;
    logic [W-1:0] rfs, rfe, rst_v;
    logic [DB-1:0] rdw;

`ifdef NCO_SWEEP_TRIANGLE_EN
    loop_exp = '{100, 110, 120, 110, 100, 110, 120};
`else
    loop_exp = '{100, 110, 120, 100, 110, 120, 100};
`endif

    //          fs       fe       st       dw n  busy  values
    tbl[0] = mk(100,     130,     10,      2, 4, 16, 100, 110, 120, 130, 0);
    tbl[1] = mk(130,     100,     25,      2, 3, 12, 130, 105, 100, 0, 0);
    tbl[2] = mk(8388600, 8388607, 5,       1, 3, 9,  8388600, 8388605, 8388607, 0, 0);
    tbl[3] = mk(500,     500,     7,       0, 1, 2,  500, 0, 0, 0, 0);
    tbl[4] = mk(40,      90,      0,       5, 1, 7,  40, 0, 0, 0, 0);
    tbl[5] = mk(0,       8388607, 8388607, 0, 2, 4,  0, 8388607, 0, 0, 0);
    tbl[6] = mk(1000,    0,       300,     1, 5, 15, 1000, 700, 400, 100, 0);
    tbl[7] = mk(8388607, 0,       8388607, 0, 2, 4,  8388607, 0, 0, 0, 0);

    rst = 1'b0; start = 1'b0; abort = 1'b0; loop_en = 1'b0;
    f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
    #23;
    check("reset_outputs", 64'(outs()), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 64'(outs()), 64'd0);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      got.delete();
      bcnt = 0; dcnt = 0; found = 1'b0;
      start_sweep(tbl[i].fs, tbl[i].fe, tbl[i].st, tbl[i].dw, 1'b0);
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (inc_upd) got.push_back(phase_inc);
        if (done) dcnt++;
        if (busy) bcnt++;
        else begin found = 1'b1; break; end
      end
      check($sformatf("tbl%0d_finished", i), 64'(found), 64'd1);
      check($sformatf("tbl%0d_nvals", i), 64'(got.size()), 64'(tbl[i].n));
      for (int k = 0; k < int'(tbl[i].n) && k < got.size(); k++)
        check($sformatf("tbl%0d_val%0d", i, k), 64'(got[k]), 64'(tbl[i].vals[k]));
      check($sformatf("tbl%0d_busy_cycles", i), 64'(bcnt), 64'(tbl[i].busy_cyc));
      check($sformatf("tbl%0d_done_pulses", i), 64'(dcnt), 64'd1);
    end

    // Loop mode: no done, values repeat.
    got.delete(); dcnt = 0;
    start_sweep(W'(100), W'(120), W'(10), DB'(0), 1'b1);
    for (int c = 0; c < 60 && got.size() < 7; c++) begin
      @(negedge clk);
      if (inc_upd) got.push_back(phase_inc);
      if (done) dcnt++;
    end
    check("loop_nvals", 64'(got.size()), 64'd7);
    for (int k = 0; k < 7 && k < got.size(); k++)
      check($sformatf("loop_val%0d", k), 64'(got[k]), 64'(loop_exp[k]));
    check("loop_no_done", 64'(dcnt), 64'd0);
    check("loop_busy", 64'(busy), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("loop_abort_idle", 64'({busy, done, inc_upd}), 64'd0);

    // Abort while dwelling on 110.
    found = 1'b0;
    start_sweep(W'(100), W'(130), W'(10), DB'(2), 1'b0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (inc_upd && phase_inc == W'(110)) begin found = 1'b1; break; end
    end
    check("abort_reach_110", 64'(found), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_outputs", 64'(outs()), {38'd0, 1'b0, 1'b0, 1'b0, W'(110)});
    for (int c = 0; c < 4; c++) @(negedge clk);
    check("abort_stays_idle", 64'(outs()), {38'd0, 1'b0, 1'b0, 1'b0, W'(110)});

    // start and abort together in IDLE: abort wins.
    f_start = W'(7); f_stop = W'(9); f_step = W'(1); dwell = DB'(1);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 64'({busy, inc_upd}), 64'd0);
    @(negedge clk);
    check("start_abort_hold", 64'(outs()), {38'd0, 1'b0, 1'b0, 1'b0, W'(110)});

    // Randomized sweeps against the reference model, with a stray start.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        rfs = W'(8388607 - $urandom_range(0, 200));
        rfe = W'(8388607 - $urandom_range(0, 200));
        rst_v = W'($urandom_range(1, 100));
      end else begin
        rfs = W'($urandom_range(0, 300));
        rfe = ($urandom_range(0, 7) == 0) ? rfs : W'($urandom_range(0, 300));
        rst_v = W'($urandom_range(3, 80));
      end
      if ($urandom_range(0, 9) == 0) rst_v = '0;
      rdw = DB'($urandom_range(0, 3));
      build_trace(longint'(rfs), longint'(rfe), longint'(rst_v), longint'(rdw));
      kpulse = $urandom_range(0, exp_q.size() - 2);
      start_sweep(rfs, rfe, rst_v, rdw, 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
        @(negedge clk);
        check($sformatf("rand%0d_cyc%0d", t, i), 64'(outs()), 64'(exp_q[i]));
        start = (i == int'(kpulse));
      end
      start = 1'b0;
    end

    // Asynchronous reset mid-sweep.
    start_sweep(W'(100), W'(130), W'(10), DB'(2), 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("midreset_outputs", 64'(outs()), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("midreset_idle%0d", c), 64'(outs()), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nco_sweep_ctrl.md
NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter PHASE_ACC_BITS, default 24, the NCO phase accumulator width; the increment width is PHASE_ACC_BITS-1.
REQ-002 The block SHALL have parameter DWELL_BITS, default 16, the width of the dwell counter.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock.
REQ-004 Port rst SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start SHALL be an input, 1 bit: a sweep request, sampled in IDLE only.
REQ-006 Port abort SHALL be an input, 1 bit: terminate the sweep immediately.
REQ-007 Port loop_en SHALL be an input, 1 bit: repeat the sweep indefinitely.
REQ-008 Ports f_start, f_stop and f_step SHALL be inputs, PHASE_ACC_BITS-1 bits each, unsigned increments: first, last and step size.
REQ-009 Port dwell SHALL be an input, DWELL_BITS bits: each frequency is held dwell+1 cycles.
REQ-010 Port phase_inc SHALL be an output, PHASE_ACC_BITS-1 bits, driving the NCO phase_inc input.
REQ-011 Port inc_upd SHALL be an output, 1 bit: a one-cycle pulse whenever phase_inc changes value or is reloaded.
REQ-012 Port busy SHALL be an output, 1 bit, high in every state except IDLE.
REQ-013 Port done SHALL be an output, 1 bit: a one-cycle pulse on normal sweep completion.

Function
REQ-014 The FSM SHALL have states IDLE, DWELL, STEP and DONE, and all outputs SHALL be registered.
REQ-015 In IDLE with start=1 and abort=0, the block SHALL latch f_start/f_stop/f_step/dwell/loop_en; next cycle phase_inc=f_start, inc_upd=1, state=DWELL, dwell counter=dwell.
REQ-016 The sweep direction SHALL be up if f_stop>=f_start and down otherwise, fixed at latch time.
REQ-017 In DWELL, the counter SHALL decrement each cycle; at 0 the state SHALL move to STEP (if phase_inc!=f_stop and f_step!=0) else to end-of-sweep handling.
REQ-018 In STEP, next = phase_inc +/- f_step SHALL be computed PHASE_ACC_BITS wide; any overshoot or wrap past f_stop SHALL clamp to f_stop; phase_inc SHALL update, inc_upd=1, counter reloads and state returns to DWELL, one cycle in STEP.
REQ-019 At end-of-sweep with latched loop_en=0, the state SHALL go to DONE, assert done for one cycle, then return to IDLE; phase_inc SHALL hold its final value.
REQ-020 At end-of-sweep with loop_en=1, phase_inc SHALL reload f_start with inc_upd=1, the state SHALL go to DWELL, and done SHALL NOT pulse.
REQ-021 f_step=0 or f_start=f_stop SHALL give a single-frequency sweep of dwell+1 cycles.
REQ-022 abort=1 in any non-IDLE state SHALL move the state to IDLE next cycle, with phase_inc held, no done and no inc_upd.
REQ-023 start while busy SHALL be ignored; start and abort together in IDLE: abort SHALL win and the sweep SHALL NOT start.
REQ-024 Input changes during a sweep SHALL have no effect until the next accepted start.

Reset
REQ-025 On rst=0, asynchronously: state=IDLE, phase_inc=0, inc_upd=0, busy=0, done=0, dwell counter=0, latched registers=0.
REQ-026 Reset mid-sweep SHALL abandon the sweep with no done pulse; after release the block SHALL wait in IDLE for start.

Configuration
REQ-027 Macro NCO_SWEEP_TRIANGLE_EN defined: in loop mode, end-of-sweep SHALL swap the direction and sweep back to f_start, alternating indefinitely, so the reload jump of REQ-020 does not occur.
REQ-028 Macro NCO_SWEEP_TRIANGLE_EN undefined: the sawtooth loop of REQ-020 SHALL apply, with no direction-swap logic present.

Structure
REQ-029 Package nco_sweep_pkg SHALL hold the state enum type and the localparam defaults for PHASE_ACC_BITS and DWELL_BITS.
REQ-030 The dwell countdown (load, decrement, zero flag) SHALL be sub-module nco_dwell_timer; step/clamp arithmetic SHALL stay in nco_sweep_ctrl.

Verification
REQ-031 Up sweep: f_start=100, f_stop=130, f_step=10, dwell=2 -> phase_inc 100,110,120,130, each held 3 cycles plus 1 STEP cycle; done 1 cycle after the 130 dwell; 4 inc_upd pulses.
REQ-032 Clamp/down: f_start=130, f_stop=100, f_step=25 -> phase_inc 130,105,100; f_start=8388600, f_stop=8388607, f_step=5 -> 8388600, 8388605, 8388607 (no wrap).
REQ-033 Loop: loop_en=1, 100->120 step 10, dwell=0 -> 100,110,120,100,... with no done; with NCO_SWEEP_TRIANGLE_EN: 100,110,120,110,100,110,...
REQ-034 Abort at 110 in DWELL -> busy=0 next cycle, phase_inc stays 110, done=0; start+abort together in IDLE -> busy stays 0.
REQ-035 rst pulsed low mid-sweep -> all outputs 0 immediately; f_step=0, dwell=5 -> one value for 6 cycles, then done.
